// File: rtl/freq_window_pkg.sv
// Shared definitions for the frequency window monitor.
// Contents:
//   state_e        - lock/fault state machine encoding (also visible in STATUS[1:0])
//   ADDR_*         - Avalon-MM word addresses of the register map
//   FREQ_INVALID   - gauge reading that means "no measurement yet"
//   STATUS_W1C_BIT - bit of STATUS that clears sticky_fault when written as 1
package freq_window_pkg;

  typedef enum logic [1:0] {
    NOSIG   = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_e;

  localparam logic [2:0] ADDR_STATUS      = 3'd0;
  localparam logic [2:0] ADDR_CURRENT     = 3'd1;
  localparam logic [2:0] ADDR_LOW         = 3'd2;
  localparam logic [2:0] ADDR_HIGH        = 3'd3;
  localparam logic [2:0] ADDR_MIN         = 3'd4;
  localparam logic [2:0] ADDR_MAX         = 3'd5;
  localparam logic [2:0] ADDR_FAULT_COUNT = 3'd6;
  localparam logic [2:0] ADDR_CONTROL     = 3'd7;

  localparam logic [31:0] FREQ_INVALID = 32'hFFFF_FFFF;

  localparam int STATUS_W1C_BIT = 8;

endpackage

// File: rtl/freq_window_monitor.sv
// Frequency window monitor.
// Samples the gauge reading every SamplePeriod clocks, checks it against an
// inclusive [LOW, HIGH] window, qualifies lock/fault with consecutive-sample
// counts and keeps min/max/fault statistics behind an Avalon-MM slave.
// Ports:
//   clk, reset_n        - reference clock, asynchronous active-low reset
//   freq_hz             - gauge reading in Hz (all ones = invalid)
//   avs_address/read/write/writedata/readdata - Avalon-MM slave, 8 words
//   irq                 - level interrupt, sticky_fault & irq_en (registered)
//   locked              - high while the state machine is LOCKED (registered)
// The FSM state is observable at any time through STATUS[1:0].
module freq_window_monitor
  import freq_window_pkg::*;
#(
  parameter int unsigned SamplePeriod = 550000,
  parameter logic [31:0] LowDefault   = 32'd0,
  parameter logic [31:0] HighDefault  = 32'hFFFF_FFFE,
  parameter int unsigned LockCount    = 4,
  parameter int unsigned FaultCount   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] freq_hz,
  input  logic [2:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic        locked
);

  localparam logic [31:0] TICK_RELOAD = 32'(SamplePeriod - 1);
  localparam logic [7:0]  LOCK_N      = 8'(LockCount);
  localparam logic [7:0]  FAULT_N     = 8'(FaultCount);

  // Bus handshake: there is no waitrequest, so every cycle with avs_read or
  // avs_write high is one accepted transfer. Writes take effect on that
  // edge; read data appears the following cycle and holds until the next read.

  logic [31:0] tick_cnt;
  logic        eval;
  logic [31:0] current;
  logic [31:0] low, high;
  logic [31:0] min_val, max_val;
  logic [15:0] fault_cnt;
  logic        sticky_fault, sticky_d;
  logic        enable, irq_en, irq_en_d;
  logic        irq_q, locked_q;
  logic [31:0] readdata_q, rd_mux;

  state_e      state_q, state_d;
  logic [7:0]  good_q, good_d, bad_q, bad_d;
  logic        fault_set;

  logic sample_valid, in_range, stat_upd;
  logic wr_status, wr_low, wr_high, wr_min, wr_max, wr_fc, wr_control;

  assign wr_status  = avs_write && (avs_address == ADDR_STATUS);
  assign wr_low     = avs_write && (avs_address == ADDR_LOW);
  assign wr_high    = avs_write && (avs_address == ADDR_HIGH);
  assign wr_min     = avs_write && (avs_address == ADDR_MIN);
  assign wr_max     = avs_write && (avs_address == ADDR_MAX);
  assign wr_fc      = avs_write && (avs_address == ADDR_FAULT_COUNT);
  assign wr_control = avs_write && (avs_address == ADDR_CONTROL);

  // Tick counter and sample capture. The counter never stops; enable only
  // gates whether a tick captures a sample and schedules an evaluation, so
  // re-enabling naturally waits for the next tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= TICK_RELOAD;
      current  <= FREQ_INVALID;
      eval     <= 1'b0;
    end else begin
      eval <= 1'b0;
      if (tick_cnt == 32'd0) begin
        tick_cnt <= TICK_RELOAD;
        if (enable) begin
          current <= freq_hz;
          eval    <= 1'b1;
        end
      end else begin
        tick_cnt <= tick_cnt - 32'd1;
      end
    end
  end

  // Range check on the captured sample with the thresholds of this cycle.
  // low > high leaves no value satisfying both bounds.
  assign sample_valid = (current != FREQ_INVALID);
  assign in_range     = sample_valid && (current >= low) && (current <= high);
  assign stat_upd     = eval && enable && sample_valid;

  // Next-state logic for the lock/fault state machine.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    bad_d     = bad_q;
    fault_set = 1'b0;
    if (!enable) begin
      state_d = NOSIG;
      good_d  = 8'd0;
      bad_d   = 8'd0;
    end else if (eval) begin
      if (!sample_valid) begin
        state_d   = NOSIG;
        good_d    = 8'd0;
        bad_d     = 8'd0;
        fault_set = (state_q == LOCKED);
      end else begin
        case (state_q)
          NOSIG: begin
            if (in_range) begin
              good_d = 8'd1;
              if (LOCK_N <= 8'd1) begin
                state_d = LOCKED;
                bad_d   = 8'd0;
              end else begin
                state_d = ACQUIRE;
              end
            end else begin
              state_d = ACQUIRE;
              good_d  = 8'd0;
            end
          end
          ACQUIRE: begin
            if (in_range) begin
              good_d = good_q + 8'd1;
              if ((good_q + 8'd1) >= LOCK_N) begin
                state_d = LOCKED;
                bad_d   = 8'd0;
              end
            end else begin
              good_d = 8'd0;
            end
          end
          LOCKED: begin
            if (in_range) begin
              bad_d = 8'd0;
            end else begin
              bad_d = bad_q + 8'd1;
              if ((bad_q + 8'd1) >= FAULT_N) begin
                state_d   = FAULT;
                fault_set = 1'b1;
              end
            end
          end
          FAULT: begin
            if (in_range) begin
              good_d = 8'd1;
              if (LOCK_N <= 8'd1) begin
                state_d = LOCKED;
                bad_d   = 8'd0;
              end else begin
                state_d = ACQUIRE;
              end
            end
          end
          default: begin
            state_d = NOSIG;
            good_d  = 8'd0;
            bad_d   = 8'd0;
          end
        endcase
      end
    end
  end

  // State register; locked is registered from the next state so it moves
  // together with STATUS[1:0].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= NOSIG;
      good_q   <= 8'd0;
      bad_q    <= 8'd0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      locked_q <= (state_d == LOCKED);
    end
  end

  // A fault set beats a same-cycle W1C, so the set is applied last.
  always_comb begin
    sticky_d = sticky_fault;
    if (wr_status && avs_writedata[STATUS_W1C_BIT]) sticky_d = 1'b0;
    if (fault_set) sticky_d = 1'b1;
  end

  assign irq_en_d = wr_control ? avs_writedata[1] : irq_en;

  // Register file and statistics. Statistic clears take priority over a
  // same-cycle update, discarding that sample for the cleared statistic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      low          <= LowDefault;
      high         <= HighDefault;
      enable       <= 1'b1;
      irq_en       <= 1'b0;
      sticky_fault <= 1'b0;
      min_val      <= FREQ_INVALID;
      max_val      <= 32'd0;
      fault_cnt    <= 16'd0;
      irq_q        <= 1'b0;
    end else begin
      if (wr_low)  low  <= avs_writedata;
      if (wr_high) high <= avs_writedata;
      if (wr_control) enable <= avs_writedata[0];
      irq_en       <= irq_en_d;
      sticky_fault <= sticky_d;
      irq_q        <= sticky_d & irq_en_d;

      if (wr_min) min_val <= FREQ_INVALID;
      else if (stat_upd && (current < min_val)) min_val <= current;

      if (wr_max) max_val <= 32'd0;
      else if (stat_upd && (current > max_val)) max_val <= current;

      if (wr_fc) fault_cnt <= 16'd0;
      else if (fault_set && (fault_cnt != 16'hFFFF)) fault_cnt <= fault_cnt + 16'd1;
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (avs_address)
      ADDR_STATUS:      rd_mux = {bad_q, good_q, 7'd0, sticky_fault, 6'd0, state_q};
      ADDR_CURRENT:     rd_mux = current;
      ADDR_LOW:         rd_mux = low;
      ADDR_HIGH:        rd_mux = high;
      ADDR_MIN:         rd_mux = min_val;
      ADDR_MAX:         rd_mux = max_val;
      ADDR_FAULT_COUNT: rd_mux = {16'd0, fault_cnt};
      ADDR_CONTROL:     rd_mux = {30'd0, irq_en, enable};
      default:          rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= 32'd0;
    else if (avs_read) readdata_q <= rd_mux;
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_freq_window_monitor.sv
// Directed bench for freq_window_monitor (SamplePeriod 16, LockCount 4,
// FaultCount 2, window 99 MHz .. 101 MHz). Inputs change on the falling
// edge; outputs are sampled on the falling edge. A bench-side cycle counter
// (cyc, posedges since reset release) locates the sample ticks: captures
// happen on edges where cyc is a multiple of 16, evaluations one edge later.
module tb_freq_window_monitor;
  import freq_window_pkg::*;

  localparam int P = 16;
  localparam logic [31:0] F_NOM = 32'd100_000_000;
  localparam logic [31:0] F_LOW = 32'd99_000_000;
  localparam logic [31:0] F_HIGH = 32'd101_000_000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] freq_hz;
  logic [2:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        irq, locked;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  logic [31:0] rdata;

  freq_window_monitor #(
    .SamplePeriod(P),
    .LowDefault(32'd0),
    .HighDefault(32'hFFFF_FFFE),
    .LockCount(4),
    .FaultCount(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .freq_hz(freq_hz),
    .avs_address(avs_address),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata),
    .irq(irq),
    .locked(locked)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers (called on a falling edge) ----------------
  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic wait_mod(input int m);
    while ((cyc % P) != m) @(negedge clk);
  endtask

  // Apply f and let n ticks capture it; returns just after the n-th
  // evaluation (cyc % 16 == 2). Callers keep bus activity inside one period.
  task automatic step(input logic [31:0] f, input int n);
    freq_hz = f;
    repeat (n) begin
      @(negedge clk);
      wait_mod(2);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0;
    freq_hz = FREQ_INVALID;
    avs_address = 3'd0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_readdata", avs_readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_locked", {31'd0, locked}, 32'd0);
    reset_n = 1'b1;

    bus_wr(ADDR_LOW, F_LOW);
    bus_wr(ADDR_HIGH, F_HIGH);

    // No signal for 10 ticks.
    step(FREQ_INVALID, 10);
    bus_rd(ADDR_STATUS, rdata);  check("nosig_status", rdata, 32'h0000_0000);
    check("nosig_locked", {31'd0, locked}, 32'd0);
    bus_rd(ADDR_MIN, rdata);     check("nosig_min", rdata, 32'hFFFF_FFFF);
    bus_rd(ADDR_MAX, rdata);     check("nosig_max", rdata, 32'd0);

    // Acquire: three in-range ticks leave good_run at 3 in ACQUIRE.
    step(F_NOM, 3);
    bus_rd(ADDR_STATUS, rdata);  check("acq3_status", rdata, 32'h0003_0001);
    // Fourth tick: locked must still be low right after the capture edge and
    // high after the evaluation edge.
    wait_mod(0);
    check("lock_edge_before", {31'd0, locked}, 32'd0);
    @(negedge clk);
    check("lock_edge_after", {31'd0, locked}, 32'd1);
    bus_rd(ADDR_STATUS, rdata);  check("locked_status", rdata, 32'h0004_0002);
    bus_rd(ADDR_MIN, rdata);     check("locked_min", rdata, F_NOM);
    bus_rd(ADDR_MAX, rdata);     check("locked_max", rdata, F_NOM);

    // One bad sample is tolerated, then the bad run resets.
    step(32'd0, 1);
    bus_rd(ADDR_STATUS, rdata);  check("bad1_status", rdata, 32'h0104_0002);
    step(F_NOM, 1);
    bus_rd(ADDR_STATUS, rdata);  check("bad_recover_status", rdata, 32'h0004_0002);
    check("bad_recover_locked", {31'd0, locked}, 32'd1);

    // Two bad samples: fault.
    step(32'd0, 2);
    bus_rd(ADDR_STATUS, rdata);  check("fault_status", rdata, 32'h0204_0103);
    bus_rd(ADDR_FAULT_COUNT, rdata); check("fault_count1", rdata, 32'd1);
    bus_rd(ADDR_MIN, rdata);     check("fault_min_zero", rdata, 32'd0);
    check("fault_locked", {31'd0, locked}, 32'd0);
    check("fault_irq_masked", {31'd0, irq}, 32'd0);

    // Interrupt enable and W1C.
    bus_wr(ADDR_CONTROL, 32'h3);
    check("irq_enabled", {31'd0, irq}, 32'd1);
    bus_wr(ADDR_STATUS, 32'h100);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    bus_rd(ADDR_STATUS, rdata);  check("w1c_status", rdata & 32'h00FF_0103, 32'h0004_0003);

    // Recovery from FAULT.
    step(F_NOM, 1);
    bus_rd(ADDR_STATUS, rdata);  check("refault_acq", rdata & 32'h00FF_0103, 32'h0001_0001);
    step(F_NOM, 3);
    check("relock_locked", {31'd0, locked}, 32'd1);

    // Inclusive window bounds.
    step(F_HIGH, 2);
    bus_rd(ADDR_STATUS, rdata);  check("at_high_status", rdata, 32'h0004_0002);
    step(F_LOW, 2);
    bus_rd(ADDR_STATUS, rdata);  check("at_low_status", rdata, 32'h0004_0002);
    bus_rd(ADDR_MAX, rdata);     check("max_at_high", rdata, F_HIGH);

    // low > high: everything out of range. Clear FAULT_COUNT on the very
    // evaluation edge that faults; the clear must win.
    bus_wr(ADDR_LOW, 32'd101_000_001);
    step(F_LOW, 1);
    wait_mod(0);
    bus_wr(ADDR_FAULT_COUNT, 32'd0);
    bus_rd(ADDR_FAULT_COUNT, rdata); check("fc_clear_wins", rdata, 32'd0);
    bus_rd(ADDR_STATUS, rdata);  check("inverted_fault", rdata, 32'h0204_0103);
    check("inverted_irq", {31'd0, irq}, 32'd1);
    bus_wr(ADDR_MIN, 32'd0);
    bus_rd(ADDR_MIN, rdata);     check("min_reset", rdata, 32'hFFFF_FFFF);
    bus_rd(ADDR_MAX, rdata);     check("max_before_reset", rdata, F_HIGH);

    // Asynchronous reset between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_locked", {31'd0, locked}, 32'd0);
    check("areset_irq", {31'd0, irq}, 32'd0);
    check("areset_readdata", avs_readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    freq_hz = F_NOM;
    bus_rd(ADDR_LOW, rdata);     check("default_low", rdata, 32'd0);
    bus_rd(ADDR_HIGH, rdata);    check("default_high", rdata, 32'hFFFF_FFFE);
    // First tick lands exactly SamplePeriod edges after release.
    while (cyc != P - 1) @(negedge clk);
    bus_rd(ADDR_CURRENT, rdata); check("current_before_tick", rdata, 32'hFFFF_FFFF);
    bus_rd(ADDR_CURRENT, rdata); check("current_after_tick", rdata, F_NOM);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
